// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// The master drives operands and accepts results; the slave is the adder.
interface nibble_serial_adder_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned WIDTH = 4 * NIBBLES;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one shared 4-bit ripple stage consumes one nibble pair per clock,
// with the carry registered between nibbles. Valid/ready on both sides.
module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_adder_if.slave bus
);
  localparam int unsigned WIDTH = 4 * NIBBLES;
  localparam int unsigned CntW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d, sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [3:0]       nib_sum;
  logic             nib_carry;
  logic [WIDTH+3:0] acc_shift;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    nib_carry = carry_q;
    for (int i = 0; i < 4; i++) begin
      nib_sum[i] = a_q[i] ^ b_q[i] ^ nib_carry;
      nib_carry  = (a_q[i] & b_q[i]) | (nib_carry & (a_q[i] ^ b_q[i]));
    end
  end

  // New nibble enters at the top so nibble 0 ends at the bottom after NIBBLES shifts.
  assign acc_shift = {nib_sum, acc_q};
  assign acc_next  = acc_shift[WIDTH+3:4];

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        acc_d   = acc_next;
        carry_d = nib_carry;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          sum_d       = acc_next;
          cout_d      = nib_carry;
          ovf_d       = (a_msb_q == b_msb_q) && (nib_sum[3] != a_msb_q);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q == StBusy);
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: a 4-nibble instance for directed/random/backpressure/reset
// cases and a 1-nibble instance swept exhaustively.
module tb_nibble_serial_adder;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  nibble_serial_adder_if #(.NIBBLES(4)) if4 ();
  nibble_serial_adder_if #(.NIBBLES(1)) if1 ();

  nibble_serial_adder #(.NIBBLES(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  nibble_serial_adder #(.NIBBLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  // Reference: plain wide arithmetic on a w-bit slice. Returns {ovf, cout, sum[15:0]}.
  function automatic logic [17:0] model(input int unsigned w, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin);
    longint unsigned mask, av, bv, full, s;
    logic            co, ov;
    mask = (64'd1 << w) - 64'd1;
    av   = 64'(a) & mask;
    bv   = 64'(b) & mask;
    full = av + bv + 64'(cin);
    s    = full & mask;
    co   = full[w];
    ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
    return {ov, co, s[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction on the 4-nibble instance with optional result backpressure
  // and optional junk on the input side while the block is occupied.
  task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input int hold, input bit noise, input string tag);
    logic [17:0] e;
    int          lat;
    int          busy_n;
    e = model(16, a, b, cin);
    @(negedge clk);
    check({tag, " in_ready idle"}, 32'(if4.in_ready), 32'd1);
    if4.in_valid = 1'b1;
    if4.a        = a;
    if4.b        = b;
    if4.cin      = cin;
    @(negedge clk);
    if (noise) begin
      if4.a = 16'hAAAA;
      if4.b = 16'hAAAA;
    end else begin
      if4.in_valid = 1'b0;
    end
    check({tag, " in_ready busy"}, 32'(if4.in_ready), 32'd0);
    lat    = 0;
    busy_n = 0;
    while (!if4.out_valid && lat < 20) begin
      if (if4.busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " busy cycles"}, 32'(busy_n), 32'd4);
    check({tag, " sum"}, 32'(if4.sum), 32'(e[15:0]));
    check({tag, " cout"}, 32'(if4.cout), 32'(e[16]));
    check({tag, " ovf"}, 32'(if4.ovf), 32'(e[17]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold out_valid"}, 32'(if4.out_valid), 32'd1);
      check({tag, " hold in_ready"}, 32'(if4.in_ready), 32'd0);
      check({tag, " hold result"}, {14'd0, if4.ovf, if4.cout, if4.sum}, {14'd0, e});
    end
    if4.out_ready = 1'b1;
    if4.in_valid  = 1'b0;
    @(negedge clk);
    if4.out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(if4.out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(if4.in_ready), 32'd1);
  endtask

  task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [17:0] e;
    int          lat;
    e = model(4, {12'd0, a}, {12'd0, b}, cin);
    @(negedge clk);
    if1.in_valid = 1'b1;
    if1.a        = a;
    if1.b        = b;
    if1.cin      = cin;
    @(negedge clk);
    if1.in_valid = 1'b0;
    lat = 0;
    while (!if1.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("n1 latency", 32'(lat), 32'd1);
    check("n1 result", {26'd0, if1.ovf, if1.cout, if1.sum}, {26'd0, e[17], e[16], e[3:0]});
  endtask

  vec_t        vecs[4];
  logic [15:0] ra, rb;
  logic        rc;
  logic [15:0] opa[3];
  logic [15:0] opb[3];
  logic        opc[3];
  int          acc_cyc[3];

  initial begin
    errors = 0;
    checks = 0;
    vecs[0] = '{a: 16'h1234, b: 16'h4321, cin: 1'b1, sum: 16'h5556, cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sum: 16'h0000, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, sum: 16'h8000, cout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, sum: 16'h0000, cout: 1'b1, ovf: 1'b1};

    rst_n         = 1'b0;
    if4.in_valid  = 1'b0;
    if4.a         = 'x;
    if4.b         = 'x;
    if4.cin       = 1'b0;
    if4.out_ready = 1'b0;
    if1.in_valid  = 1'b0;
    if1.a         = '0;
    if1.b         = '0;
    if1.cin       = 1'b0;
    if1.out_ready = 1'b1;

    #12;
    check("reset in_ready", 32'(if4.in_ready), 32'd1);
    check("reset out_valid", 32'(if4.out_valid), 32'd0);
    check("reset sum", 32'(if4.sum), 32'd0);
    check("reset cout_ovf_busy", {29'd0, if4.cout, if4.ovf, if4.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // X on idle operands must not leak into the stored result.
    check("idle x no capture", 32'(if4.sum), 32'd0);

    for (int i = 0; i < 4; i++) begin
      logic [17:0] m;
      m = model(16, vecs[i].a, vecs[i].b, vecs[i].cin);
      check("table vs model", {14'd0, m}, {14'd0, vecs[i].ovf, vecs[i].cout, vecs[i].sum});
      run4(vecs[i].a, vecs[i].b, vecs[i].cin, 0, 1'b0, $sformatf("vec%0d", i));
    end

    run4(16'h1357, 16'h2468, 1'b0, 5, 1'b1, "backpressure");

    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      run4(ra, rb, rc, int'($urandom_range(0, 3)), 1'($urandom), $sformatf("rand%0d", i));
    end

    // Abort in the second BUSY cycle; outputs must clear without waiting for an edge.
    @(negedge clk);
    if4.in_valid = 1'b1;
    if4.a        = 16'h00FF;
    if4.b        = 16'h0F01;
    if4.cin      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if4.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midop out_valid", 32'(if4.out_valid), 32'd0);
    check("midop sum", 32'(if4.sum), 32'd0);
    check("midop busy", 32'(if4.busy), 32'd0);
    check("midop in_ready", 32'(if4.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run4(16'h0001, 16'h0001, 1'b0, 0, 1'b0, "post reset");

    // Back-to-back with out_ready tied high and in_valid held.
    begin
      int  cyc;
      int  idx;
      int  nout;
      bit  adv;
      for (int i = 0; i < 3; i++) begin
        opa[i] = 16'($urandom);
        opb[i] = 16'($urandom);
        opc[i] = 1'($urandom);
      end
      @(negedge clk);
      if4.out_ready = 1'b1;
      if4.in_valid  = 1'b1;
      if4.a         = opa[0];
      if4.b         = opb[0];
      if4.cin       = opc[0];
      cyc  = 0;
      idx  = 0;
      nout = 0;
      adv  = 1'b0;
      acc_cyc[0] = 0;
      if (if4.in_ready) begin
        adv = 1'b1;
      end
      while (nout < 3 && cyc < 60) begin
        @(negedge clk);
        cyc++;
        if (if4.out_valid) begin
          logic [17:0] e;
          e = model(16, opa[nout], opb[nout], opc[nout]);
          check($sformatf("b2b result%0d", nout), {14'd0, if4.ovf, if4.cout, if4.sum},
                {14'd0, e});
          nout++;
        end
        if (adv) begin
          adv = 1'b0;
          idx++;
          if (idx < 3) begin
            if4.a   = opa[idx];
            if4.b   = opb[idx];
            if4.cin = opc[idx];
          end else begin
            if4.in_valid = 1'b0;
          end
        end
        if (if4.in_ready && idx < 3 && if4.in_valid) begin
          acc_cyc[idx] = cyc;
          adv = 1'b1;
        end
      end
      check("b2b results seen", 32'(nout), 32'd3);
      check("b2b spacing 0-1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
      check("b2b spacing 1-2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
      if4.in_valid  = 1'b0;
      if4.out_ready = 1'b0;
    end

    // Single-nibble instance: spot check then exhaustive sweep.
    run1(4'hF, 4'h1, 1'b0);
    check("n1 F+1 sum", 32'(if1.sum), 32'd0);
    check("n1 F+1 cout", 32'(if1.cout), 32'd1);
    check("n1 F+1 ovf", 32'(if1.ovf), 32'd0);
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      run1(v[3:0], v[7:4], v[8]);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
